registro_datos_rtc: RTL and testbench

REGISTRO_DATOS_RTC -- requirements
Module: registro_datos_rtc

---
 rtl/registro_datos_rtc.sv | 180 ++++++++++++++++++
 tb/tb_registro_datos_rtc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/registro_datos_rtc.sv
// registro_datos_rtc
// Collects the nine bytes of one RTC read frame into a shadow copy and
// loads all nine committed outputs together once every field has been
// captured. Incomplete frames are aborted when the read window closes or
// when captures stop for TIMEOUT_CICLOS cycles.
//
// Optional feature: define BCD_CHECK_EN to reject frames that contain a
// byte with a nibble above 9. A rejected frame pulses error_bcd instead of
// dato_nuevo and leaves the committed values untouched.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   lectura_activa    read-frame window from the read sequencer
//   rd                active-low RTC read strobe
//   dato_rtc[7:0]     RTC AD bus, valid while rd is low
//   dat_sel[8:0]      one-hot field select
//                     {hora_tim,min_tim,seg_tim,anio,mes,dia,hora,min,seg}
//   seg..hora_tim     committed BCD values
//   dato_nuevo        one-cycle pulse when a frame is committed
//   frame_abortado    one-cycle pulse when a frame is aborted
//   error_bcd         one-cycle pulse when a frame is rejected
//   timer_cero        committed seg_tim, min_tim and hora_tim all zero
module registro_datos_rtc #(
  parameter int TIMEOUT_CICLOS = 512
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lectura_activa,
  input  logic       rd,
  input  logic [7:0] dato_rtc,
  input  logic [8:0] dat_sel,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic [7:0] seg_tim,
  output logic [7:0] min_tim,
  output logic [7:0] hora_tim,
  output logic       dato_nuevo,
  output logic       frame_abortado,
  output logic       error_bcd,
  output logic       timer_cero
);

  localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CICLOS);

  typedef enum logic [1:0] {IDLE, CAPTURA, COMMIT} estado_t;

  estado_t       estado;
  estado_t       estado_sig;
  logic [7:0]    dato_q;
  logic          rd_q;
  logic [8:0]    mask;
  logic [CW-1:0] cnt;
  logic [7:0]    shadow [9];
  logic [7:0]    salida [9];

  logic sel_onehot;
  logic captura;
  logic mask_llena;
  logic abortar;
  logic entrar;
  logic commit;
  logic carga;

  // State register
  always_ff @(posedge clk) begin
    if (reset) estado <= IDLE;
    else       estado <= estado_sig;
  end

  // Next-state logic; a full mask wins over an abort in the same cycle
  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE:    if (lectura_activa) estado_sig = CAPTURA;
      CAPTURA: begin
        if (mask_llena)   estado_sig = COMMIT;
        else if (abortar) estado_sig = IDLE;
      end
      COMMIT:  estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  // Control decode. A capture is the rising edge of rd; the byte is taken
  // from dato_q, i.e. the value the bus held while rd was still low.
  always_comb begin
    sel_onehot = (dat_sel != 9'd0) && ((dat_sel & (dat_sel - 9'd1)) == 9'd0);
    mask_llena = (mask == 9'h1FF);
    entrar     = (estado == IDLE) && lectura_activa;
    captura    = (estado == CAPTURA) && rd && !rd_q && sel_onehot;
    abortar    = (estado == CAPTURA) && !mask_llena &&
                 (!lectura_activa || (cnt == CNT_MAX));
    commit     = (estado == COMMIT);
  end

  // Input registers and frame bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      dato_q <= 8'h00;
      rd_q   <= 1'b1;
      mask   <= 9'd0;
      cnt    <= '0;
      for (int i = 0; i < 9; i++) shadow[i] <= 8'h00;
    end else begin
      dato_q <= dato_rtc;
      rd_q   <= rd;
      if (entrar) begin
        mask <= 9'd0;
        cnt  <= '0;
      end else if (estado == CAPTURA) begin
        if (captura) begin
          mask <= mask | dat_sel;
          cnt  <= '0;
          for (int i = 0; i < 9; i++)
            if (dat_sel[i]) shadow[i] <= dato_q;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

`ifdef BCD_CHECK_EN
  logic invalido;

  // Sticky per-frame flag: any captured byte with a non-decimal nibble
  always_ff @(posedge clk) begin
    if (reset)
      invalido <= 1'b0;
    else if (entrar)
      invalido <= 1'b0;
    else if (captura && ((dato_q[7:4] > 4'd9) || (dato_q[3:0] > 4'd9)))
      invalido <= 1'b1;
  end

  assign carga = commit && !invalido;

  always_ff @(posedge clk) begin
    if (reset) error_bcd <= 1'b0;
    else       error_bcd <= commit && invalido;
  end
`else
  assign carga     = commit;
  assign error_bcd = 1'b0;
`endif

  // Committed registers load together so readers never see a mixed frame
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) salida[i] <= 8'h00;
      dato_nuevo     <= 1'b0;
      frame_abortado <= 1'b0;
    end else begin
      if (carga)
        for (int i = 0; i < 9; i++) salida[i] <= shadow[i];
      dato_nuevo     <= carga;
      frame_abortado <= abortar;
    end
  end

  assign seg      = salida[0];
  assign min      = salida[1];
  assign hora     = salida[2];
  assign dia      = salida[3];
  assign mes      = salida[4];
  assign anio     = salida[5];
  assign seg_tim  = salida[6];
  assign min_tim  = salida[7];
  assign hora_tim = salida[8];

  // Derived from the committed timer only, never from the shadow copy
  assign timer_cero = (salida[6] == 8'h00) && (salida[7] == 8'h00) &&
                      (salida[8] == 8'h00);

endmodule

// File: tb/tb_registro_datos_rtc.sv
// Testbench for registro_datos_rtc: table of full frames with expected
// commit/timer_cero results, plus hand-written abort, timeout, invalid
// select and mid-frame reset sequences. Expected committed values travel
// through a queue from the stimulus side to the result checker.
module tb_registro_datos_rtc;

  localparam int TIMEOUT = 512;

  logic       clk = 1'b0;
  logic       reset;
  logic       lectura_activa;
  logic       rd;
  logic [7:0] dato_rtc;
  logic [8:0] dat_sel;
  logic [7:0] seg, min, hora, dia, mes, anio, seg_tim, min_tim, hora_tim;
  logic       dato_nuevo, frame_abortado, error_bcd, timer_cero;
  logic [71:0] dut_vals;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [71:0] vals;
    logic        es_error;
  } exp_t;

  typedef struct packed {
    logic [71:0] datos;
    logic        exp_commit;
    logic        exp_tc;
  } vec_t;

  exp_t        cola[$];
  logic [71:0] modelo;
  vec_t        vecs [5];

  registro_datos_rtc #(.TIMEOUT_CICLOS(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .lectura_activa(lectura_activa), .rd(rd),
    .dato_rtc(dato_rtc), .dat_sel(dat_sel),
    .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
    .seg_tim(seg_tim), .min_tim(min_tim), .hora_tim(hora_tim),
    .dato_nuevo(dato_nuevo), .frame_abortado(frame_abortado),
    .error_bcd(error_bcd), .timer_cero(timer_cero)
  );

  assign dut_vals = {hora_tim, min_tim, seg_tim, anio, mes, dia, hora, min, seg};

  always #5 clk = ~clk;

  task checkOutput(input string nombre, input logic [71:0] actual,
                   input logic [71:0] esperado);
    checks++;
    if (actual !== esperado) begin
      failures++;
      $display("[TB] FAIL %s actual=%h esperado=%h", nombre, actual, esperado);
    end
  endtask

  task tick();
    @(posedge clk);
    #1;
  endtask

  // One read: bus valid with rd low, then rd rises with the field select
  task capturar(input logic [8:0] sel, input logic [7:0] dato);
    rd = 1'b0; dato_rtc = dato; dat_sel = 9'd0;
    tick();
    rd = 1'b1; dat_sel = sel;
    tick();
    dat_sel = 9'd0;
  endtask

  task pushExpected(input logic [71:0] datos, input logic commit_ok);
    exp_t e;
    e.es_error = !commit_ok;
    if (commit_ok) modelo = datos;
    e.vals = modelo;
    cola.push_back(e);
  endtask

  task applyStimulus(input vec_t v);
    lectura_activa = 1'b1;
    tick();
    pushExpected(v.datos, v.exp_commit);
    for (int i = 0; i < 9; i++)
      capturar(9'(1 << i), v.datos[i*8 +: 8]);
  endtask

  // Called right after the final capture edge E: pulse expected after E+2
  task waitResult(input string nombre, input logic exp_tc);
    exp_t e;
    if (cola.size() == 0) begin
      checkOutput({nombre, "_cola"}, 72'd0, 72'd1);
    end else begin
      e = cola.pop_front();
      tick();
      checkOutput({nombre, "_temprano"}, {70'd0, dato_nuevo, error_bcd}, 72'd0);
      tick();
      checkOutput({nombre, "_pulso"}, {70'd0, dato_nuevo, error_bcd},
                  e.es_error ? 72'd1 : 72'd2);
      checkOutput({nombre, "_salidas"}, dut_vals, e.vals);
      checkOutput({nombre, "_timer_cero"}, {71'd0, timer_cero}, {71'd0, exp_tc});
      tick();
      checkOutput({nombre, "_fin_pulso"}, {70'd0, dato_nuevo, error_bcd}, 72'd0);
    end
    lectura_activa = 1'b0;
    tick();
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout esperado=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  n;
    bit  visto;
    vec_t v;

    vecs[0] = '{datos: {8'h00,8'h00,8'h00,8'h16,8'h10,8'h25,8'h12,8'h34,8'h59},
                exp_commit: 1'b1, exp_tc: 1'b1};
    vecs[1] = '{datos: {8'h03,8'h02,8'h01,8'h99,8'h12,8'h31,8'h23,8'h59,8'h59},
                exp_commit: 1'b1, exp_tc: 1'b0};
    vecs[2] = '{datos: {8'h00,8'h00,8'h01,8'h00,8'h01,8'h01,8'h00,8'h00,8'h00},
                exp_commit: 1'b1, exp_tc: 1'b0};
`ifdef BCD_CHECK_EN
    vecs[3] = '{datos: {8'h00,8'h00,8'h00,8'h16,8'h10,8'h25,8'h12,8'h34,8'h5A},
                exp_commit: 1'b0, exp_tc: 1'b0};
`else
    vecs[3] = '{datos: {8'h00,8'h00,8'h00,8'h16,8'h10,8'h25,8'h12,8'h34,8'h5A},
                exp_commit: 1'b1, exp_tc: 1'b1};
`endif
    vecs[4] = '{datos: {8'h00,8'h00,8'h00,8'h00,8'h01,8'h01,8'h00,8'h00,8'h00},
                exp_commit: 1'b1, exp_tc: 1'b1};

    reset = 1'b1; lectura_activa = 1'b0; rd = 1'b1;
    dato_rtc = 8'h00; dat_sel = 9'd0; modelo = 72'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checkOutput("reset_salidas", dut_vals, 72'd0);
    checkOutput("reset_pulsos", {69'd0, dato_nuevo, frame_abortado, error_bcd}, 72'd0);
    checkOutput("reset_timer_cero", {71'd0, timer_cero}, 72'd1);

    for (int k = 0; k < 5; k++) begin
      applyStimulus(vecs[k]);
      waitResult($sformatf("tabla%0d", k), vecs[k].exp_tc);
    end

    // Five captures, then the window closes: abort, outputs unchanged
    lectura_activa = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) capturar(9'(1 << i), 8'h44);
    lectura_activa = 1'b0;
    tick();
    checkOutput("abort_pulso", {70'd0, frame_abortado, dato_nuevo}, 72'd2);
    tick();
    checkOutput("abort_fin_pulso", {71'd0, frame_abortado}, 72'd0);
    checkOutput("abort_salidas", dut_vals, modelo);

    // Captures stop with the window open: abort after the timeout
    lectura_activa = 1'b1;
    tick();
    capturar(9'h001, 8'h11);
    capturar(9'h002, 8'h22);
    n = 0;
    visto = 1'b0;
    while (frame_abortado !== 1'b1 && n < TIMEOUT + 100) begin
      tick();
      n++;
      if (dato_nuevo) visto = 1'b1;
    end
    checkOutput("timeout_pulso", {71'd0, frame_abortado}, 72'd1);
    checkOutput("timeout_ciclos", {71'd0, (n >= TIMEOUT && n <= TIMEOUT + 2)}, 72'd1);
    checkOutput("timeout_sin_dato_nuevo", {71'd0, visto}, 72'd0);
    checkOutput("timeout_salidas", dut_vals, modelo);
    v = '{datos: {8'h00,8'h00,8'h00,8'h21,8'h07,8'h14,8'h08,8'h15,8'h30},
          exp_commit: 1'b1, exp_tc: 1'b1};
    applyStimulus(v);
    waitResult("tras_timeout", 1'b1);

    // Multi-hot and zero selects are ignored; the frame needs seg still
    lectura_activa = 1'b1;
    tick();
    v.datos = {8'h05,8'h04,8'h03,8'h18,8'h06,8'h09,8'h17,8'h45,8'h42};
    for (int i = 1; i < 9; i++) capturar(9'(1 << i), v.datos[i*8 +: 8]);
    capturar(9'h003, 8'h77);
    capturar(9'h000, 8'h66);
    visto = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dato_nuevo || error_bcd) visto = 1'b1;
    end
    checkOutput("sel_invalido_sin_commit", {71'd0, visto}, 72'd0);
    pushExpected(v.datos, 1'b1);
    capturar(9'h001, 8'h42);
    waitResult("sel_invalido", 1'b0);

    // Reset asserted on the seventh capture: everything cleared, no pulses
    lectura_activa = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) capturar(9'(1 << i), 8'h33);
    rd = 1'b0; dato_rtc = 8'h33;
    tick();
    rd = 1'b1; dat_sel = 9'h040; reset = 1'b1; lectura_activa = 1'b0;
    tick();
    reset = 1'b0; dat_sel = 9'd0;
    modelo = 72'd0;
    visto = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (dato_nuevo || frame_abortado || error_bcd) visto = 1'b1;
      tick();
    end
    checkOutput("reset_frame_salidas", dut_vals, modelo);
    checkOutput("reset_frame_timer_cero", {71'd0, timer_cero}, 72'd1);
    checkOutput("reset_frame_sin_pulsos", {71'd0, visto}, 72'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
